// File: rtl/match_controller_if.sv
// Signal bundle between the press detectors / light field and match_controller.
// Event pulses (start, l_press, r_press) are one-cycle strobes; round_over/left_won are levels.
interface match_controller_if #(
  parameter int SCORE_W = 3
);
  logic               start;
  logic               l_press;
  logic               r_press;
  logic               round_over;
  logic               left_won;
  logic               l_gated;
  logic               r_gated;
  logic               field_reset;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               match_over;
  logic               match_winner;
  logic [2:0]         state_dbg;

  modport master (
    output start, l_press, r_press, round_over, left_won,
    input  l_gated, r_gated, field_reset, score_l, score_r,
    input  match_over, match_winner, state_dbg
  );

  modport slave (
    input  start, l_press, r_press, round_over, left_won,
    output l_gated, r_gated, field_reset, score_l, score_r,
    output match_over, match_winner, state_dbg
  );
endinterface

// File: rtl/match_controller.sv
// Best-of-N tug-of-war sequencer: countdown, play, result hold and match end,
// gating player presses into the light field and keeping per-player round scores.
module match_controller #(
  parameter int WIN_ROUNDS = 3,
  parameter int SCORE_W    = 3,
  parameter int COUNT_CYC  = 50000000,
  parameter int HOLD_CYC   = 25000000,
  parameter int TMR_W      = 26
) (
  input  logic                clk,
  input  logic                reset,
  match_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    HOLD      = 3'd3,
    MATCH_END = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_ROUNDS);
  localparam logic [TMR_W-1:0]   COUNT_END = TMR_W'(COUNT_CYC - 1);
  localparam logic [TMR_W-1:0]   HOLD_END  = TMR_W'(HOLD_CYC - 1);

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [SCORE_W-1:0] score_l, score_l_nxt;
  logic [SCORE_W-1:0] score_r, score_r_nxt;
  logic               field_reset;
  logic               field_reset_nxt;
  logic [SCORE_W-1:0] score_l_inc;
  logic [SCORE_W-1:0] score_r_inc;
  logic               play_open;

  // Saturating increments so a score can never wrap past the winning count.
  assign score_l_inc = (score_l == WIN) ? score_l : score_l + SCORE_W'(1);
  assign score_r_inc = (score_r == WIN) ? score_r : score_r + SCORE_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      score_l     <= '0;
      score_r     <= '0;
      field_reset <= 1'b1;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      score_l     <= score_l_nxt;
      score_r     <= score_r_nxt;
      field_reset <= field_reset_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    score_l_nxt = score_l;
    score_r_nxt = score_r;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = COUNTDOWN;
          timer_nxt = '0;
        end
      end

      COUNTDOWN: begin
        if (timer == COUNT_END) begin
          state_nxt = PLAY;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      PLAY: begin
        if (bus.round_over) begin
          timer_nxt = '0;
          if (bus.left_won) begin
            score_l_nxt = score_l_inc;
            state_nxt   = (score_l_inc == WIN) ? MATCH_END : HOLD;
          end else begin
            score_r_nxt = score_r_inc;
            state_nxt   = (score_r_inc == WIN) ? MATCH_END : HOLD;
          end
        end
      end

      HOLD: begin
        if (timer == HOLD_END) begin
          state_nxt = COUNTDOWN;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      MATCH_END: begin
        if (bus.start) begin
          score_l_nxt = '0;
          score_r_nxt = '0;
          state_nxt   = COUNTDOWN;
          timer_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // The field stays centred only while idle or counting down; in HOLD and
  // MATCH_END it is released so the winning position remains visible.
  assign field_reset_nxt = (state_nxt == IDLE) || (state_nxt == COUNTDOWN);

  assign play_open = (state == PLAY) && !bus.round_over;

  assign bus.l_gated      = play_open && bus.l_press;
  assign bus.r_gated      = play_open && bus.r_press;
  assign bus.field_reset  = field_reset;
  assign bus.score_l      = score_l;
  assign bus.score_r      = score_r;
  assign bus.match_over   = (state == MATCH_END);
  assign bus.match_winner = (state == MATCH_END) && (score_l == WIN);
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with short countdown/hold timers.
module tb_match_controller;

  localparam int WIN_ROUNDS = 3;
  localparam int SCORE_W    = 3;
  localparam int COUNT_CYC  = 4;
  localparam int HOLD_CYC   = 3;
  localparam int TMR_W      = 4;

  localparam int S_IDLE      = 0;
  localparam int S_COUNTDOWN = 1;
  localparam int S_PLAY      = 2;
  localparam int S_HOLD      = 3;
  localparam int S_MATCH_END = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  match_controller_if #(.SCORE_W(SCORE_W)) mif ();

  match_controller #(
    .WIN_ROUNDS (WIN_ROUNDS),
    .SCORE_W    (SCORE_W),
    .COUNT_CYC  (COUNT_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .TMR_W      (TMR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; one step crosses exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input int st, input int fr,
                              input int sl, input int sr);
    chk({tag, ".state"}, int'(mif.state_dbg), st);
    chk({tag, ".field_reset"}, int'(mif.field_reset), fr);
    chk({tag, ".score_l"}, int'(mif.score_l), sl);
    chk({tag, ".score_r"}, int'(mif.score_r), sr);
  endtask

  // Called in PLAY at a falling edge: reports one round result for a single cycle.
  task automatic win_round(input logic left);
    mif.round_over = 1'b1;
    mif.left_won   = left;
    step();
    mif.round_over = 1'b0;
    mif.left_won   = 1'b0;
  endtask

  // From the first HOLD cycle, HOLD + COUNTDOWN dwell back to PLAY.
  task automatic hold_to_play();
    repeat (HOLD_CYC + COUNT_CYC) step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset          = 1'b0;
    mif.start      = 1'b0;
    mif.l_press    = 1'b0;
    mif.r_press    = 1'b0;
    mif.round_over = 1'b0;
    mif.left_won   = 1'b0;

    // 1: reset state
    repeat (2) step();
    check_status("rst", S_IDLE, 1, 0, 0);
    chk("rst.match_over", int'(mif.match_over), 0);
    chk("rst.match_winner", int'(mif.match_winner), 0);
    reset = 1'b1;
    step();
    check_status("idle", S_IDLE, 1, 0, 0);

    // 2: countdown dwell with presses blocked
    mif.start   = 1'b1;
    mif.l_press = 1'b1;
    step();
    mif.start = 1'b0;
    for (int i = 0; i < COUNT_CYC; i++) begin
      chk($sformatf("cd%0d.state", i), int'(mif.state_dbg), S_COUNTDOWN);
      chk($sformatf("cd%0d.field_reset", i), int'(mif.field_reset), 1);
      chk($sformatf("cd%0d.l_gated", i), int'(mif.l_gated), 0);
      step();
    end
    check_status("play1", S_PLAY, 0, 0, 0);
    chk("play1.l_gated", int'(mif.l_gated), 1);
    mif.l_press = 1'b0;
    #1 chk("play1.l_gated_low", int'(mif.l_gated), 0);
    mif.r_press = 1'b1;
    #1 chk("play1.r_gated", int'(mif.r_gated), 1);
    mif.r_press = 1'b0;

    // 3: left round win, hold, countdown, back to play
    mif.l_press    = 1'b1;
    mif.round_over = 1'b1;
    mif.left_won   = 1'b1;
    #1 chk("rnd.l_masked", int'(mif.l_gated), 0);
    step();
    mif.l_press  = 1'b0;
    mif.left_won = 1'b0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      check_status($sformatf("hold%0d", i), S_HOLD, 0, 1, 0);
      step();
    end
    mif.round_over = 1'b0;
    for (int i = 0; i < COUNT_CYC; i++) begin
      check_status($sformatf("cd2_%0d", i), S_COUNTDOWN, 1, 1, 0);
      step();
    end
    check_status("play2", S_PLAY, 0, 1, 0);

    // 4: three right wins end the match
    win_round(1'b0);
    check_status("r1", S_HOLD, 0, 1, 1);
    hold_to_play();
    chk("r1.play", int'(mif.state_dbg), S_PLAY);
    win_round(1'b0);
    check_status("r2", S_HOLD, 0, 1, 2);
    hold_to_play();
    chk("r2.play", int'(mif.state_dbg), S_PLAY);
    win_round(1'b0);
    check_status("r3", S_MATCH_END, 0, 1, 3);
    chk("r3.match_over", int'(mif.match_over), 1);
    chk("r3.match_winner", int'(mif.match_winner), 0);
    mif.round_over = 1'b1;
    mif.left_won   = 1'b1;
    mif.l_press    = 1'b1;
    #1 chk("end.l_gated", int'(mif.l_gated), 0);
    step();
    mif.round_over = 1'b0;
    mif.left_won   = 1'b0;
    mif.l_press    = 1'b0;
    check_status("end.ignore", S_MATCH_END, 0, 1, 3);
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    check_status("restart", S_COUNTDOWN, 1, 0, 0);
    chk("restart.match_over", int'(mif.match_over), 0);
    repeat (COUNT_CYC) step();
    chk("restart.play", int'(mif.state_dbg), S_PLAY);

    // 5: simultaneous presses, then masked by round_over
    mif.l_press = 1'b1;
    mif.r_press = 1'b1;
    #1 chk("both.l", int'(mif.l_gated), 1);
    chk("both.r", int'(mif.r_gated), 1);
    mif.round_over = 1'b1;
    #1 chk("both_ro.l", int'(mif.l_gated), 0);
    chk("both_ro.r", int'(mif.r_gated), 0);
    mif.round_over = 1'b0;
    mif.l_press    = 1'b0;
    mif.r_press    = 1'b0;

    // 6: async reset in the middle of HOLD with score_l=2
    win_round(1'b1);
    hold_to_play();
    win_round(1'b1);
    check_status("l2", S_HOLD, 0, 2, 0);
    step();
    #2 reset = 1'b0;
    #1 check_status("async_rst", S_IDLE, 1, 0, 0);
    step();
    reset = 1'b1;
    step();
    check_status("post_rst", S_IDLE, 1, 0, 0);

    // start while playing is ignored; then a left match win
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    repeat (COUNT_CYC) step();
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    check_status("start_in_play", S_PLAY, 0, 0, 0);
    win_round(1'b1);
    hold_to_play();
    win_round(1'b1);
    hold_to_play();
    win_round(1'b1);
    check_status("lwin", S_MATCH_END, 0, 3, 0);
    chk("lwin.match_over", int'(mif.match_over), 1);
    chk("lwin.match_winner", int'(mif.match_winner), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
